// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the i2c command sequencer: program op codes, error codes,
// FSM state encoding and the byte-level i2c core command codes.
package i2c_seq_pkg;

   localparam int PROG_W = 12;

   localparam logic [3:0] OP_START   = 4'h1;
   localparam logic [3:0] OP_RESTART = 4'h2;
   localparam logic [3:0] OP_STOP    = 4'h3;
   localparam logic [3:0] OP_WRITE   = 4'h4;
   localparam logic [3:0] OP_READ    = 4'h5;
   localparam logic [3:0] OP_DELAY   = 4'h6;
   localparam logic [3:0] OP_END     = 4'h7;

   localparam logic [2:0] K_START_CMD   = 3'b000;
   localparam logic [2:0] K_WRITE_CMD   = 3'b001;
   localparam logic [2:0] K_READ_CMD    = 3'b010;
   localparam logic [2:0] K_STOP_CMD    = 3'b011;
   localparam logic [2:0] K_RESTART_CMD = 3'b100;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_NACK   = 2'd1;
   localparam logic [1:0] ERR_BAD_OP = 2'd2;
   localparam logic [1:0] ERR_PC_OVF = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_ISSUE,
      S_WAIT_DONE,
      S_DLY,
      S_ABORT_ISSUE,
      S_ABORT_WAIT,
      S_FINISH
   } state_e;

   function automatic logic op_is_bus(input logic [3:0] op);
      op_is_bus = (op == OP_START) || (op == OP_RESTART) || (op == OP_STOP) ||
                  (op == OP_WRITE) || (op == OP_READ);
   endfunction

   function automatic logic [2:0] op_to_cmd(input logic [3:0] op);
      case (op)
         OP_START:   op_to_cmd = K_START_CMD;
         OP_RESTART: op_to_cmd = K_RESTART_CMD;
         OP_WRITE:   op_to_cmd = K_WRITE_CMD;
         OP_READ:    op_to_cmd = K_READ_CMD;
         default:    op_to_cmd = K_STOP_CMD;
      endcase
   endfunction

endpackage

// File: rtl/i2c_seq_ram.sv
// Program store for the sequencer: one write port, registered read port.
module i2c_seq_ram
   import i2c_seq_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [PROG_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [PROG_W-1:0] rdata
);

   logic [PROG_W-1:0] mem_q [2**ADDR_W];
   logic [PROG_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/i2c_seq.sv
// i2c command sequencer: runs {op,arg} programs from a writable RAM against the
// byte-level i2c core, with read capture, timed delays, NACK retry and error reporting.
module i2c_seq
   import i2c_seq_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int DELAY_UNIT  = 1000,
   parameter int MAX_RETRIES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done_tick,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W-1:0] err_pc,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [11:0]       prog_data,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic              i2c_write,
   output logic [2:0]        i2c_cmd,
   output logic [7:0]        i2c_data_in,
   input  logic              i2c_ready,
   input  logic              i2c_done_tick,
   input  logic              i2c_ack,
   input  logic [7:0]        i2c_data_out
);

   // state        | meaning
   // IDLE / FETCH | wait for go / RAM read of pc;  EXEC | decode fetched word
   // ISSUE / WAIT_DONE | strobe command when core ready / wait for its done_tick
   // DLY | delay countdown;  ABORT_ISSUE / ABORT_WAIT | STOP after NACK;  FINISH | done_tick

   localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
   localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [ADDR_W-1:0] PC_LAST = '1;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  start_q, start_d;
   logic [ADDR_W-1:0]  err_pc_q, err_pc_d;
   logic [RET_W-1:0]   retry_q, retry_d;
   logic [3:0]         op_q, op_d;
   logic [7:0]         arg_q, arg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         err_code_q, err_code_d;
   logic               rd_valid_q, rd_valid_d;
   logic [7:0]         rd_data_q, rd_data_d;
   logic               advance;

   logic [PROG_W-1:0]  ram_rdata;
   logic               ram_we;
   logic [3:0]         fetch_op;
   logic [7:0]         fetch_arg;

   assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign done_tick = (state_q == S_FINISH);
   assign error     = (err_code_q != ERR_NONE);
   assign err_code  = err_code_q;
   assign err_pc    = err_pc_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

   assign ram_we    = prog_we && !busy;
   assign fetch_op  = ram_rdata[11:8];
   assign fetch_arg = ram_rdata[7:0];

   i2c_seq_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      start_d     = start_q;
      err_pc_d    = err_pc_q;
      retry_d     = retry_q;
      op_d        = op_q;
      arg_d       = arg_q;
      cnt_d       = cnt_q;
      err_code_d  = err_code_q;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
      advance     = 1'b0;
      i2c_write   = 1'b0;
      i2c_cmd     = 3'b000;
      i2c_data_in = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               pc_d       = start_addr;
               start_d    = start_addr;
               retry_d    = '0;
               err_code_d = ERR_NONE;
               err_pc_d   = '0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            op_d  = fetch_op;
            arg_d = fetch_arg;
            if (fetch_op == OP_END) begin
               state_d = S_FINISH;
            end else if (fetch_op == OP_DELAY) begin
               cnt_d   = CNT_W'(fetch_arg) * CNT_W'(DELAY_UNIT);
               state_d = S_DLY;
            end else if (op_is_bus(fetch_op)) begin
               state_d = S_ISSUE;
            end else begin
               err_code_d = ERR_BAD_OP;
               err_pc_d   = pc_q;
               state_d    = S_FINISH;
            end
         end
         S_ISSUE: begin
            if (i2c_ready) begin
               i2c_write   = 1'b1;
               i2c_cmd     = op_to_cmd(op_q);
               i2c_data_in = (op_q == OP_READ) ? {7'b0, arg_q[0]} : arg_q;
               state_d     = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (i2c_done_tick) begin
               if ((op_q == OP_WRITE) && !i2c_ack) begin
                  state_d = S_ABORT_ISSUE;
               end else begin
                  if (op_q == OP_READ) begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = i2c_data_out;
                  end
                  advance = 1'b1;
               end
            end
         end
         S_DLY: begin
            if (cnt_q == '0) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ABORT_ISSUE: begin
            if (i2c_ready) begin
               i2c_write = 1'b1;
               i2c_cmd   = K_STOP_CMD;
               state_d   = S_ABORT_WAIT;
            end
         end
         S_ABORT_WAIT: begin
            // pc still points at the NACKed WRITE here, which is what err_pc reports
            if (i2c_done_tick) begin
               if (retry_q < RET_W'(MAX_RETRIES)) begin
                  retry_d = retry_q + 1'b1;
                  pc_d    = start_q;
                  state_d = S_FETCH;
               end else begin
                  err_code_d = ERR_NACK;
                  err_pc_d   = pc_q;
                  state_d    = S_FINISH;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (advance) begin
         if (pc_q == PC_LAST) begin
            err_code_d = ERR_PC_OVF;
            err_pc_d   = pc_q;
            state_d    = S_FINISH;
         end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         start_q    <= '0;
         err_pc_q   <= '0;
         retry_q    <= '0;
         op_q       <= 4'h0;
         arg_q      <= 8'h00;
         cnt_q      <= '0;
         err_code_q <= ERR_NONE;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         start_q    <= start_d;
         err_pc_q   <= err_pc_d;
         retry_q    <= retry_d;
         op_q       <= op_d;
         arg_q      <= arg_d;
         cnt_q      <= cnt_d;
         err_code_q <= err_code_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

endmodule

// File: tb/tb_i2c_seq.sv
// Scoreboard bench for i2c_seq with a behavioural byte-level i2c core model.
module tb_i2c_seq;

   localparam int AW = 5;
   localparam logic [2:0] C_START = 3'd0;
   localparam logic [2:0] C_WRITE = 3'd1;
   localparam logic [2:0] C_READ  = 3'd2;
   localparam logic [2:0] C_STOP  = 3'd3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          go = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic          busy, done_tick, error;
   logic [1:0]    err_code;
   logic [AW-1:0] err_pc;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [11:0]   prog_data = '0;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic          i2c_write;
   logic [2:0]    i2c_cmd;
   logic [7:0]    i2c_data_in;
   logic          m_ready, m_done, m_ack;
   logic [7:0]    m_dout;
   logic [1:0]    m_cnt;
   logic          nack_all = 1'b0;
   logic [7:0]    rd_byte = 8'h00;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int rd_cnt = 0;
   int nd = 0;
   int base, go_cyc, rbase;
   int wr_time[$];
   logic [10:0] exp_wr[$];
   logic [7:0]  exp_done[$];
   logic [7:0]  exp_rd[$];
   logic [10:0] ew;
   logic [7:0]  ed, er;

   i2c_seq #(
      .ADDR_W(AW),
      .DELAY_UNIT(10),
      .MAX_RETRIES(2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .go            (go),
      .start_addr    (start_addr),
      .busy          (busy),
      .done_tick     (done_tick),
      .error         (error),
      .err_code      (err_code),
      .err_pc        (err_pc),
      .prog_we       (prog_we),
      .prog_addr     (prog_addr),
      .prog_data     (prog_data),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .i2c_write     (i2c_write),
      .i2c_cmd       (i2c_cmd),
      .i2c_data_in   (i2c_data_in),
      .i2c_ready     (m_ready),
      .i2c_done_tick (m_done),
      .i2c_ack       (m_ack),
      .i2c_data_out  (m_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // core model: done_tick (with ready back) 4 cycles after an accepted strobe
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ready <= 1'b1;
         m_done  <= 1'b0;
         m_cnt   <= 2'd0;
         m_ack   <= 1'b0;
         m_dout  <= 8'h00;
      end else begin
         m_done <= 1'b0;
         if (m_ready && i2c_write) begin
            m_ready <= 1'b0;
            m_cnt   <= 2'd2;
         end else if (!m_ready) begin
            if (m_cnt == 2'd0) begin
               m_done  <= 1'b1;
               m_ready <= 1'b1;
               m_ack   <= !nack_all;
               m_dout  <= rd_byte;
            end else begin
               m_cnt <= m_cnt - 2'd1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (i2c_write) begin
            wr_time.push_back(cyc);
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got cmd=%0d data=%02h, required no strobe",
                        i2c_cmd, i2c_data_in);
            end else begin
               ew = exp_wr.pop_front();
               chk("strobe_cmd_data", 32'({i2c_cmd, i2c_data_in}), 32'(ew));
            end
         end
         if (done_tick) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy), 32'(0));
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got err_code=%0d, required no done_tick", err_code);
            end else begin
               ed = exp_done.pop_front();
               chk("done_error", 32'(error), 32'(ed[7]));
               chk("done_err_code", 32'(err_code), 32'(ed[6:5]));
               if (ed[7]) chk("done_err_pc", 32'(err_pc), 32'(ed[4:0]));
            end
         end
         if (rd_valid) begin
            rd_cnt++;
            if (exp_rd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rd_valid: got %02h, required no read", rd_data);
            end else begin
               er = exp_rd.pop_front();
               chk("rd_data", 32'(rd_data), 32'(er));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pwrite(input logic [AW-1:0] a, input logic [11:0] d);
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic pulse_go(input logic [AW-1:0] a);
      go = 1'b1;
      start_addr = a;
      tick();
      go = 1'b0;
   endtask

   task automatic push_wr(input logic [2:0] c, input logic [7:0] d);
      exp_wr.push_back({c, d});
   endtask

   task automatic push_done(input logic [1:0] code, input logic [AW-1:0] pc);
      exp_done.push_back({(code != 2'd0), code, pc});
   endtask

   task automatic wait_dones(input int target, input string name);
      for (int i = 0; i < 800 && done_cnt < target; i++) @(negedge clk);
      chk({name, "_done_count"}, 32'(done_cnt), 32'(target));
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("reset_outputs", 32'({busy, done_tick, error, err_code, err_pc, rd_valid, rd_data,
                               i2c_write, i2c_cmd, i2c_data_in}), 32'(0));

      // 1: basic write program; word 0 written in the same cycle as go
      pwrite(5'd1, 12'h44E);
      pwrite(5'd2, 12'h4F3);
      pwrite(5'd3, 12'h300);
      pwrite(5'd4, 12'h700);
      push_wr(C_START, 8'h00);
      push_wr(C_WRITE, 8'h4E);
      push_wr(C_WRITE, 8'hF3);
      push_wr(C_STOP, 8'h00);
      push_done(2'd0, 5'd0);
      base = wr_time.size();
      go_cyc = cyc;
      prog_we = 1'b1; prog_addr = 5'd0; prog_data = 12'h100;
      go = 1'b1; start_addr = 5'd0;
      tick();
      prog_we = 1'b0; go = 1'b0;
      chk("busy_after_go", 32'(busy), 32'(1));
      nd++;
      wait_dones(nd, "t1");
      chk("t1_go_to_write_latency", 32'(wr_time[base] - go_cyc), 32'(3));
      chk("t1_strobe_count", 32'(wr_time.size() - base), 32'(4));

      // 2: read with NACK-last flag
      pwrite(5'd8, 12'h100);
      pwrite(5'd9, 12'h44F);
      pwrite(5'd10, 12'h501);
      pwrite(5'd11, 12'h300);
      pwrite(5'd12, 12'h700);
      rd_byte = 8'hA5;
      push_wr(C_START, 8'h00);
      push_wr(C_WRITE, 8'h4F);
      push_wr(C_READ, 8'h01);
      push_wr(C_STOP, 8'h00);
      exp_rd.push_back(8'hA5);
      push_done(2'd0, 5'd0);
      rbase = rd_cnt;
      pulse_go(5'd8);
      nd++;
      wait_dones(nd, "t2");
      chk("t2_rd_valid_count", 32'(rd_cnt - rbase), 32'(1));

      // 3: every WRITE NACKed, two retries then error
      pwrite(5'd16, 12'h100);
      pwrite(5'd17, 12'h44E);
      pwrite(5'd18, 12'h300);
      pwrite(5'd19, 12'h700);
      nack_all = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_wr(C_START, 8'h00);
         push_wr(C_WRITE, 8'h4E);
         push_wr(C_STOP, 8'h00);
      end
      push_done(2'd1, 5'd17);
      base = wr_time.size();
      pulse_go(5'd16);
      nd++;
      wait_dones(nd, "t3");
      chk("t3_strobe_count", 32'(wr_time.size() - base), 32'(9));
      nack_all = 1'b0;

      // 4: DELAY 0 and DELAY 3 with DELAY_UNIT=10
      pwrite(5'd24, 12'h100);
      pwrite(5'd25, 12'h600);
      pwrite(5'd26, 12'h455);
      pwrite(5'd27, 12'h603);
      pwrite(5'd28, 12'h300);
      pwrite(5'd29, 12'h700);
      push_wr(C_START, 8'h00);
      push_wr(C_WRITE, 8'h55);
      push_wr(C_STOP, 8'h00);
      push_done(2'd0, 5'd0);
      base = wr_time.size();
      pulse_go(5'd24);
      nd++;
      wait_dones(nd, "t4");
      chk("t4_gap_delay0", 32'(wr_time[base + 1] - wr_time[base]), 32'(10));
      chk("t4_gap_delay3", 32'(wr_time[base + 2] - wr_time[base + 1]), 32'(40));
      chk("t4_delay3_extra", 32'((wr_time[base + 2] - wr_time[base + 1]) -
                                  (wr_time[base + 1] - wr_time[base])), 32'(30));

      // 5a: bad opcode at address 2
      pwrite(5'd0, 12'h600);
      pwrite(5'd1, 12'h600);
      pwrite(5'd2, 12'hF00);
      push_done(2'd2, 5'd2);
      pulse_go(5'd0);
      nd++;
      wait_dones(nd, "t5a");

      // 5b: run off the end of RAM; a wrap would hit the bad opcode at 2 instead
      pwrite(5'd28, 12'h600);
      pwrite(5'd29, 12'h600);
      pwrite(5'd30, 12'h600);
      pwrite(5'd31, 12'h100);
      push_wr(C_START, 8'h00);
      push_done(2'd3, 5'd31);
      pulse_go(5'd28);
      nd++;
      wait_dones(nd, "t5b");

      // 6a: reset while waiting for the core
      push_wr(C_START, 8'h00);
      base = wr_time.size();
      pulse_go(5'd8);
      for (int i = 0; i < 100 && wr_time.size() == base; i++) @(negedge clk);
      chk("t6_first_strobe_seen", 32'(wr_time.size() - base), 32'(1));
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_outputs_after_reset", 32'({busy, done_tick, error, err_code, err_pc, rd_valid,
                                        rd_data, i2c_write, i2c_cmd, i2c_data_in}), 32'(0));
      tick();
      reset = 1'b0;
      repeat (20) tick();
      chk("t6_no_pending_strobes", 32'(exp_wr.size()), 32'(0));
      chk("t6_no_done_after_reset", 32'(done_cnt), 32'(nd));

      // 6b: go and prog_we while busy are ignored
      pwrite(5'd28, 12'h300);
      pwrite(5'd29, 12'h700);
      push_wr(C_START, 8'h00);
      push_wr(C_WRITE, 8'h55);
      push_wr(C_STOP, 8'h00);
      push_done(2'd0, 5'd0);
      pulse_go(5'd24);
      repeat (8) tick();
      chk("t6b_busy_mid_run", 32'(busy), 32'(1));
      prog_we = 1'b1; prog_addr = 5'd9; prog_data = 12'h4AA;
      go = 1'b1; start_addr = 5'd8;
      tick();
      prog_we = 1'b0; go = 1'b0;
      nd++;
      wait_dones(nd, "t6b");
      rd_byte = 8'h3C;
      push_wr(C_START, 8'h00);
      push_wr(C_WRITE, 8'h4F);
      push_wr(C_READ, 8'h01);
      push_wr(C_STOP, 8'h00);
      exp_rd.push_back(8'h3C);
      push_done(2'd0, 5'd0);
      pulse_go(5'd8);
      nd++;
      wait_dones(nd, "t6b_rerun");

      repeat (10) tick();
      chk("final_exp_wr_empty", 32'(exp_wr.size()), 32'(0));
      chk("final_exp_done_empty", 32'(exp_done.size()), 32'(0));
      chk("final_exp_rd_empty", 32'(exp_rd.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
